// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl: shares one 8-bit Fibonacci LFSR among NREQ round-robin requesters
module lfsr_share_ctrl #(
  parameter int         NREQ         = 4,
  parameter int         WARMUP       = 8,
  parameter logic [7:0] SEED_DEFAULT = 8'h80
) (
  input  logic            clk,
  input  logic            NReset,
  input  logic [NREQ-1:0] req,
  input  logic            seed_we,
  input  logic [7:0]      seed_in,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd,
  output logic            rnd_valid,
  output logic            ready,
  output logic [7:0]      lfsr_q
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {WARM, SERVE} state_t;
  localparam state_t START = (WARMUP == 0) ? SERVE : WARM;
  localparam logic [7:0] LAST = 8'(WARMUP - 1);
  state_t          state;
  logic [7:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic            hit;
  logic [7:0]      nxt;
  assign nxt   = {lfsr_q[7] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[1], lfsr_q[7:1]};
  assign ready = (state == SERVE);
  // Round-robin pick: lowest requester at or above the pointer, else lowest below it
  always_comb begin
    hit = |req;
    sel = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && PW'(i) < ptr) sel = PW'(i);
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && PW'(i) >= ptr) sel = PW'(i);
  end
  // Reset > reseed > warm-up step > grant; grant outputs are one-cycle pulses
  always_ff @(posedge clk) begin
    if (!NReset) begin
      lfsr_q    <= SEED_DEFAULT;
      state     <= START;
      cnt       <= '0;
      ptr       <= '0;
      gnt       <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (seed_we) begin
        lfsr_q <= (seed_in == 8'h00) ? SEED_DEFAULT : seed_in;
        cnt    <= '0;
        state  <= START;
      end else if (state == WARM) begin
        lfsr_q <= nxt;
        cnt    <= cnt + 8'd1;
        if (cnt == LAST) state <= SERVE;
      end else if (hit) begin
        gnt       <= NREQ'(1) << sel;
        rnd       <= lfsr_q;
        rnd_valid <= 1'b1;
        lfsr_q    <= nxt;
        ptr       <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule
